// File: rtl/ib_ram_pkg.sv
// Shared loader state encoding, page/frame geometry helpers and LUT bank field positions.
package ib_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } ld_state_e;

  // The page index is everything below the frame-offset MSB of the page address.
  function automatic int page_bits(input int entry_addr);
    return entry_addr - 1;
  endfunction

  function automatic int page_num(input int entry_addr);
    return 1 << page_bits(entry_addr);
  endfunction

  localparam int LUT_PORT_SIZE_DEF = 2;
  localparam int BANK_NUM_DEF      = 2;
  localparam int BANK0_MSB         = LUT_PORT_SIZE_DEF * BANK_NUM_DEF - 1;
  localparam int BANK0_LSB         = LUT_PORT_SIZE_DEF * (BANK_NUM_DEF - 1);
  localparam int BANK1_MSB         = BANK0_LSB - 1;
  localparam int BANK1_LSB         = 0;

endpackage

// File: rtl/ib_ram_wr_reg.sv
// Registered RAM write stage: a beat accepted in cycle N appears as we/addr/data in N+1.
// Address and data hold their last values between beats; no backpressure.
module ib_ram_wr_reg #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          beat_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= beat_i;
      if (beat_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/ib_ram_page_loader.sv
// Ping-pong IB-LUT page loader: one page written per accepted beat (1-cycle write latency), frame done in PAGE_NUM+1 cycles.
// lut_data_ready is high only in LOAD; the source holds its word otherwise and stalls are waited out indefinitely.
module ib_ram_page_loader
  import ib_ram_pkg::*;
#(
  parameter int ENTRY_ADDR      = 4,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int BANK_NUM        = 2,
  parameter int LUT_PORT_SIZE   = 2,
  parameter int ITER_NUM        = 20
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              iter_update_req,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_data_in,
  input  logic                              lut_data_valid,
  output logic                              lut_data_ready,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_0,
  output logic                              ib_ram_we,
  output logic                              fresh_frame,
  output logic                              load_done,
  output logic                              busy,
  output logic [4:0]                        iter_cnt,
  output logic                              all_loaded
);

  localparam int                PAGE_W    = page_bits(ENTRY_ADDR);
  localparam int                PAGE_NUM  = page_num(ENTRY_ADDR);
  localparam int                FRAME_W   = $clog2(MULTI_FRAME_NUM);
  localparam int                DW        = LUT_PORT_SIZE * BANK_NUM;
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGE_NUM - 1);
  localparam logic [4:0]        ITER_MAX  = 5'(ITER_NUM);

  ld_state_e          state_q;
  logic [PAGE_W-1:0]  page_q;
  logic [FRAME_W-1:0] target_q;
  logic [FRAME_W-1:0] fresh_q;
  logic               pending_q;
  logic               done_q;
  logic [4:0]         iter_q;
  logic [4:0]         iter_d;
  logic               all_q;
  logic               beat;

  assign beat   = (state_q == ST_LOAD) && lut_data_valid;
  assign iter_d = (iter_q == ITER_MAX) ? iter_q : iter_q + 5'd1;

  // Frame bookkeeping moves on the last beat's edge so it lines up with that page's write.
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      page_q    <= '0;
      target_q  <= FRAME_W'(1);
      fresh_q   <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      iter_q    <= '0;
      all_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iter_update_req && !all_q) begin
            state_q <= ST_LOAD;
            page_q  <= '0;
          end
        end
        ST_LOAD: begin
          if (iter_update_req) pending_q <= 1'b1;
          if (beat) begin
            page_q <= page_q + PAGE_W'(1);
            if (page_q == PAGE_LAST) begin
              state_q  <= ST_FIN;
              done_q   <= 1'b1;
              fresh_q  <= target_q;
              target_q <= ~target_q;
              iter_q   <= iter_d;
              all_q    <= (iter_d == ITER_MAX);
            end
          end
        end
        ST_FIN: begin
          pending_q <= 1'b0;
          page_q    <= '0;
          if ((pending_q || iter_update_req) && !all_q) state_q <= ST_LOAD;
          else                                          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ib_ram_wr_reg #(
    .AW (ENTRY_ADDR),
    .DW (DW)
  ) u_wr_reg (
    .clk_i  (write_clk),
    .rst_i  (rst),
    .beat_i (beat),
    .addr_i ({target_q, page_q}),
    .data_i (lut_data_in),
    .we_o   (ib_ram_we),
    .addr_o (page_addr_ram),
    .data_o (ram_write_data_0)
  );

  assign lut_data_ready = (state_q == ST_LOAD);
  assign busy           = (state_q != ST_IDLE);
  assign fresh_frame    = fresh_q;
  assign load_done      = done_q;
  assign iter_cnt       = iter_q;
  assign all_loaded     = all_q;

endmodule

// File: tb/tb_ib_ram_page_loader.sv
// Randomized scoreboard bench for ib_ram_page_loader against a frame/page arithmetic model.
module tb_ib_ram_page_loader;

  logic       write_clk = 1'b0;
  logic       rst = 1'b1;
  logic       iter_update_req = 1'b0;
  logic [3:0] lut_data_in = '0;
  logic       lut_data_valid = 1'b0;
  logic       lut_data_ready;
  logic [3:0] page_addr_ram;
  logic [3:0] ram_write_data_0;
  logic       ib_ram_we;
  logic       fresh_frame;
  logic       load_done;
  logic       busy;
  logic [4:0] iter_cnt;
  logic       all_loaded;

  ib_ram_page_loader dut (
    .write_clk        (write_clk),
    .rst              (rst),
    .iter_update_req  (iter_update_req),
    .lut_data_in      (lut_data_in),
    .lut_data_valid   (lut_data_valid),
    .lut_data_ready   (lut_data_ready),
    .page_addr_ram    (page_addr_ram),
    .ram_write_data_0 (ram_write_data_0),
    .ib_ram_we        (ib_ram_we),
    .fresh_frame      (fresh_frame),
    .load_done        (load_done),
    .busy             (busy),
    .iter_cnt         (iter_cnt),
    .all_loaded       (all_loaded)
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] data;
    logic       done;
    logic [4:0] iter;
    logic       fresh;
  } exp_t;

  exp_t exp_q[$];
  int   wr_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   beat_total = 0;

  always @(posedge write_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: loads since reset alternate frames 1,0,1,...; every 8 accepted beats form one load.
  function automatic int frame_of(input int li);
    return (li % 2 == 0) ? 1 : 0;
  endfunction

  task automatic push_beat(input logic [3:0] d);
    exp_t e;
    int li, pg;
    li = beat_total / 8;
    pg = beat_total % 8;
    e.addr  = 4'((frame_of(li) << 3) | pg);
    e.data  = d;
    e.done  = (pg == 7);
    e.iter  = 5'((pg == 7) ? ((li + 1 > 20) ? 20 : li + 1) : li);
    e.fresh = (pg == 7) ? 1'(frame_of(li)) : ((li == 0) ? 1'b0 : 1'(frame_of(li - 1)));
    exp_q.push_back(e);
    beat_total++;
  endtask

  always @(negedge write_clk) begin
    if (!rst) begin
      if (ib_ram_we) begin
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", int'(page_addr_ram), int'(e.addr));
          chk("wr_data", int'(ram_write_data_0), int'(e.data));
          chk("load_done", int'(load_done), int'(e.done));
          chk("iter_cnt", int'(iter_cnt), int'(e.iter));
          chk("fresh_frame", int'(fresh_frame), int'(e.fresh));
        end
      end else if (load_done) begin
        chk("done_without_we", 1, 0);
      end
    end
  end

  task automatic do_req();
    @(negedge write_clk);
    iter_update_req = 1'b1;
    @(negedge write_clk);
    iter_update_req = 1'b0;
  endtask

  // fixed=1 sends 1,2,3,...; otherwise random words. Valid drops for stall_len cycles after stall_after beats.
  task automatic stream(input int nbeats, input bit fixed, input int stall_after, input int stall_len);
    int sent = 0;
    int stalled = 0;
    int guard;
    while (sent < nbeats) begin
      @(negedge write_clk);
      if (sent == stall_after && stalled < stall_len) begin
        lut_data_valid = 1'b0;
        stalled++;
        continue;
      end
      lut_data_valid = 1'b1;
      lut_data_in = fixed ? 4'(sent + 1) : 4'($urandom_range(0, 15));
      guard = 0;
      while (!lut_data_ready) begin
        @(negedge write_clk);
        guard++;
        if (guard > 50) begin
          chk("ready_timeout", 0, 1);
          lut_data_valid = 1'b0;
          return;
        end
      end
      push_beat(lut_data_in);
      sent++;
    end
    @(negedge write_clk);
    lut_data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int iter0;
    #12;
    chk("rst_we", int'(ib_ram_we), 0);
    chk("rst_addr", int'(page_addr_ram), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(lut_data_ready), 0);
    chk("rst_iter", int'(iter_cnt), 0);
    chk("rst_fresh", int'(fresh_frame), 0);
    @(negedge write_clk);
    rst = 1'b0;

    // Single full-rate load with data 1..8 into frame 1.
    base = wr_cyc.size();
    do_req();
    stream(8, 1'b1, 99, 0);
    repeat (2) @(negedge write_clk);
    chk("load1_contiguous", wr_cyc[base + 7] - wr_cyc[base], 7);
    chk("load1_fresh", int'(fresh_frame), 1);
    chk("load1_iter", int'(iter_cnt), 1);

    // Second load lands in frame 0.
    do_req();
    stream(8, 1'b0, 99, 0);
    repeat (2) @(negedge write_clk);
    chk("load2_fresh", int'(fresh_frame), 0);
    chk("load2_iter", int'(iter_cnt), 2);

    // Three-cycle stall after beat 4.
    base = wr_cyc.size();
    do_req();
    stream(8, 1'b0, 4, 3);
    repeat (2) @(negedge write_clk);
    chk("stall_gap", wr_cyc[base + 4] - wr_cyc[base + 3], 4);

    // Three requests during a load: one pending load follows FIN directly.
    base = wr_cyc.size();
    iter0 = int'(iter_cnt);
    do_req();
    fork
      stream(16, 1'b0, 99, 0);
      begin
        repeat (3) begin
          repeat (2) @(negedge write_clk);
          iter_update_req = 1'b1;
          @(negedge write_clk);
          iter_update_req = 1'b0;
        end
      end
    join
    repeat (4) @(negedge write_clk);
    chk("pending_no_idle_gap", wr_cyc[base + 8] - wr_cyc[base + 7], 2);
    chk("pending_loads", int'(iter_cnt) - iter0, 2);
    chk("pending_busy_after", int'(busy), 0);

    // Reset after beat 5 abandons the partial frame.
    do_req();
    stream(5, 1'b0, 99, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_we", int'(ib_ram_we), 0);
    chk("midrst_addr", int'(page_addr_ram), 0);
    chk("midrst_data", int'(ram_write_data_0), 0);
    chk("midrst_done", int'(load_done), 0);
    chk("midrst_fresh", int'(fresh_frame), 0);
    chk("midrst_iter", int'(iter_cnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pending_writes", exp_q.size(), 0);
    exp_q.delete();
    beat_total = 0;
    repeat (2) @(negedge write_clk);
    rst = 1'b0;

    // Fill to saturation with random words and stalls.
    while (beat_total < 20 * 8) begin
      do_req();
      stream(8, 1'b0, $urandom_range(0, 8), $urandom_range(0, 3));
    end
    repeat (3) @(negedge write_clk);
    chk("sat_all_loaded", int'(all_loaded), 1);
    chk("sat_iter", int'(iter_cnt), 20);

    // A request once saturated is ignored.
    do_req();
    lut_data_valid = 1'b1;
    repeat (3) @(negedge write_clk);
    chk("sat_req_busy", int'(busy), 0);
    chk("sat_req_ready", int'(lut_data_ready), 0);
    lut_data_valid = 1'b0;
    repeat (3) @(negedge write_clk);
    chk("sat_iter_hold", int'(iter_cnt), 20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ib_ram_page_loader.md
Name: ib_ram_page_loader

Overview:
- Iteration-update loader upstream of cnu6_f0's IB-LUT RAM write port.
- On each iteration-update request, accepts a stream of LUT words and writes one full page set into one multi-frame half of the RAM.
- Drives page_addr_ram, ram_write_data_0 and ib_ram_we.
- Ping-pongs frames, so the read datapath keeps using the other half; it then reports which frame is fresh, to steer read_addr_offset.

Parameters:
- ENTRY_ADDR, 4, total page address width; MSB is the frame offset.
- MULTI_FRAME_NUM, 2, number of frames; fixed at 2 (one offset bit).
- BANK_NUM, 2, banks per page word.
- LUT_PORT_SIZE, 2, bits per bank entry.
- ITER_NUM, 20, maximum number of loads before the loader locks.
- PAGE_NUM (localparam), 2**(ENTRY_ADDR-1) = 8, pages per frame.

Ports:
- write_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- iter_update_req  in  1  single-cycle load request.
- lut_data_in  in  LUT_PORT_SIZE*BANK_NUM  stream word; bank0 in the upper half.
- lut_data_valid  in  1  stream valid.
- lut_data_ready  out  1  stream ready.
- page_addr_ram  out  ENTRY_ADDR  write address: {frame, page}.
- ram_write_data_0  out  LUT_PORT_SIZE*BANK_NUM  write data.
- ib_ram_we  out  1  write enable.
- fresh_frame  out  1  frame most recently completed.
- load_done  out  1  one-cycle pulse when a frame is complete.
- busy  out  1  a load is in progress.
- iter_cnt  out  5  number of completed loads; saturates at ITER_NUM.
- all_loaded  out  1  iter_cnt == ITER_NUM.

Behaviour:
- Reset: all outputs 0; state IDLE; page counter 0; target frame 1 (so the first load fills frame 1 while frame 0 is in use); pending flag 0.
- Reset is asynchronous at any time, including mid-load. A partial frame is abandoned; fresh_frame stays 0 and no load_done is issued.
- FSM:
  - IDLE: iter_update_req=1 and all_loaded=0 -> LOAD; page counter := 0.
  - LOAD: lut_data_ready=1. Each beat (valid&&ready) writes one page. The beat for page PAGE_NUM-1 -> FIN.
  - FIN: one cycle, ready=0. Pulse load_done; fresh_frame := target; target toggles; iter_cnt increments, saturating. Then -> LOAD if pending=1 (pending cleared), else -> IDLE.
- busy = (state != IDLE).
- Write timing: a beat accepted in cycle N gives, in cycle N+1:
  - ib_ram_we = 1
  - page_addr_ram = {target, page}
  - ram_write_data_0 = lut_data_in as captured at N
- Outputs are registered. Between beats, ib_ram_we = 0; address and data hold their last values.
- Back-to-back beats are accepted at one per cycle. A full frame at full rate takes PAGE_NUM + 1 cycles (LOAD plus FIN).
- load_done falls in the same cycle as the we for the last page, so it is visible at N+1 of the last beat.
- Page counter is (ENTRY_ADDR-1) bits; it wraps to 0 at FIN.
- Request while busy: sets the one-deep pending flag. Further requests while pending=1 are dropped.
- A request in the same cycle as FIN counts as pending and is served immediately.
- Request when all_loaded=1: ignored; no state change.
- lut_data_valid while not in LOAD: ignored (ready=0; source holds the word).
- Stall (valid=0 in LOAD): the FSM waits indefinitely. No timeout.

Decomposition:
- Shared package ib_ram_pkg:
  - loader state enum (IDLE, LOAD, FIN)
  - PAGE_NUM / frame-bit derivation function
  - bank field slice constants
- Optional sub-module: ib_ram_wr_reg, the registered we/address/data output stage. The FSM and counters stay in the top.

Test Plan:
- Reset then single load: req at cycle 2; 8 back-to-back beats 0x1..0x8 -> we high for 8 cycles, page_addr_ram 0x8..0xF, data 0x1..0x8, load_done with last write, fresh_frame=1, iter_cnt=1.
- Second load -> page_addr_ram 0x0..0x7; fresh_frame=0; iter_cnt=2.
- Stall: valid dropped for 3 cycles after beat 4 -> we gaps of exactly 3 cycles; addresses still contiguous; load_done after beat 8.
- Two reqs during a load, plus a third -> exactly one pending load starts right after FIN, with no IDLE cycle; the third req is dropped; total loads = 2.
- Reset asserted after beat 5 -> all outputs 0 immediately; next req writes frame 1 starting at page 0.
- 20 loads completed -> all_loaded=1, iter_cnt=20; 21st req -> busy stays 0, no we.
